rotate_stream_stage: RTL

- Streaming front/back end for the N-bit right-rotate barrel shifter.
- Upstream side: accepts rotate commands (data, amount, direction) on a valid/ready interface.
- Normalises each command to a right-rotate amount and registers it onto the rotator's inputs.
- Downstream side: captures the rotator's combinational result into an output FIFO presented with valid/ready and backpressure.

---
 rtl/rotate_stream_stage.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/rotate_stream_stage.sv
// ---------------------------------------------------------------------------
// rotate_stream_stage
//
// Streaming wrapper around an external N-bit right-rotate barrel shifter.
// Commands (data, amount, direction) arrive on a valid/ready interface, get
// normalised to a right-rotate amount and registered onto the rotator's
// inputs. The rotator's combinational result is captured one cycle later
// into a small result FIFO that is presented downstream with valid/ready.
//
// Parameters:
//   N      data width (power of two, >= 4)
//   DEPTH  result FIFO entries (>= 2; >= 3 sustains one command per cycle)
//
// Ports:
//   clk, rst               clock (rising edge), synchronous active-high reset
//   in_valid/in_ready      upstream command handshake
//   in_data, in_amt,in_dir command word, rotate amount (MSB ignored), 0=right
//   rot_data, rot_amt      registered operands driven to the rotator
//   rot_f                  rotator result, combinational from rot_data/rot_amt
//   out_valid/out_ready    downstream handshake
//   out_data               FIFO head word
//
// Optional feature (macro ROT_PARITY_EN):
//   out_parity             stored parity of the FIFO head's input word
//   parity_err             sticky flag: a captured result's parity differed
//                          from its input word's parity
// ---------------------------------------------------------------------------
module rotate_stream_stage #(
   parameter  int N     = 8,
   parameter  int DEPTH = 4,
   localparam int N1    = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [N-1:0]  in_data,
   input  logic [N1:0]   in_amt,
   input  logic          in_dir,
   output logic [N-1:0]  rot_data,
   output logic [N1:0]   rot_amt,
   input  logic [N-1:0]  rot_f,
   output logic          out_valid,
   input  logic          out_ready,
`ifdef ROT_PARITY_EN
   output logic          out_parity,
   output logic          parity_err,
`endif
   output logic [N-1:0]  out_data
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic            s1_valid_q, s1_valid_d;
   logic [N-1:0]    rot_data_q, rot_data_d;
   logic [N1-1:0]   rot_amt_q,  rot_amt_d;
   logic [N-1:0]    mem_q [DEPTH];
   logic [N-1:0]    mem_d [DEPTH];
   logic [PW-1:0]   wptr_q, wptr_d;
   logic [PW-1:0]   rptr_q, rptr_d;
   logic [CW-1:0]   count_q, count_d;

`ifdef ROT_PARITY_EN
   logic            s1_par_q, s1_par_d;
   logic            par_mem_q [DEPTH];
   logic            par_mem_d [DEPTH];
   logic            perr_q, perr_d;
`endif

   logic            accept;
   logic            push;
   logic            pop;
   logic [N1-1:0]   amt_mod;
   logic [N1-1:0]   amt_right;
   logic [CW:0]     occupancy;
   logic            unused_amt_msb;

   // The amount MSB only exists so callers can pass N itself; it is dropped.
   assign unused_amt_msb = in_amt[N1];

   // Admission control counts the word still sitting in S1 as already
   // occupying a FIFO slot, because S1 cannot stall and will write it next
   // edge. Only registered state feeds this, so in_ready has no path from
   // out_ready or in_valid; it is also held low throughout the reset cycle.
   always_comb begin
      occupancy = {1'b0, count_q} + {{CW{1'b0}}, s1_valid_q};
      in_ready  = !rst && (occupancy < (CW + 1)'(DEPTH));
   end

   assign accept    = in_valid && in_ready;
   assign push      = s1_valid_q;
   assign out_valid = (count_q != '0);
   assign pop       = out_valid && out_ready;

   // A left rotate by a equals a right rotate by (N - a) mod N. Doing the
   // subtraction in N1 bits gives the mod for free and maps left-0 to 0.
   always_comb begin
      amt_mod   = in_amt[N1-1:0];
      amt_right = in_dir ? ({N1{1'b0}} - amt_mod) : amt_mod;
   end

   // Next-state for S1, FIFO storage, pointers and occupancy. S1 reloads
   // only on accept, so rot_* hold their previous operands when idle.
   // Pointers wrap with an explicit compare so non-power-of-two depths work.
   always_comb begin
      s1_valid_d = accept;
      rot_data_d = rot_data_q;
      rot_amt_d  = rot_amt_q;
      mem_d      = mem_q;
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      count_d    = count_q;

      if (accept) begin
         rot_data_d = in_data;
         rot_amt_d  = amt_right;
      end

      if (push) begin
         mem_d[wptr_q] = rot_f;
         wptr_d = (wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
      end

      if (pop) begin
         rptr_d = (rptr_q == PW'(DEPTH - 1)) ? '0 : rptr_q + 1'b1;
      end

      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // State registers. The storage array is cleared too, so that out_data
   // reads as zero after reset rather than exposing stale words.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         rot_data_q <= '0;
         rot_amt_q  <= '0;
         mem_q      <= '{default: '0};
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         rot_data_q <= rot_data_d;
         rot_amt_q  <= rot_amt_d;
         mem_q      <= mem_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         count_q    <= count_d;
      end
   end

   assign rot_data = rot_data_q;
   assign rot_amt  = {1'b0, rot_amt_q};
   assign out_data = mem_q[rptr_q];

`ifdef ROT_PARITY_EN
   // Rotation preserves parity, so the input word's parity travels with the
   // command and is compared against the rotator's output at capture time.
   always_comb begin
      s1_par_d  = s1_par_q;
      par_mem_d = par_mem_q;
      perr_d    = perr_q;
      if (accept) begin
         s1_par_d = ^in_data;
      end
      if (push) begin
         par_mem_d[wptr_q] = s1_par_q;
         if ((^rot_f) != s1_par_q) begin
            perr_d = 1'b1;
         end
      end
   end

   // Parity registers; the error flag is sticky until reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_par_q  <= 1'b0;
         par_mem_q <= '{default: 1'b0};
         perr_q    <= 1'b0;
      end else begin
         s1_par_q  <= s1_par_d;
         par_mem_q <= par_mem_d;
         perr_q    <= perr_d;
      end
   end

   assign out_parity = par_mem_q[rptr_q];
   assign parity_err = perr_q;
`endif

endmodule
